// File: rtl/timer_dev.sv
// Programmable down-counting timer on the CPU device bridge. It supports one-shot and
// auto-reload modes and raises a maskable interrupt when the count expires.
//
// state | meaning
// IDLE  | stopped, COUNT held, waiting for EN
// LOAD  | COUNT takes PRESET
// CNT   | decrementing toward expiry
// INT   | expired; one-shot drops EN, auto-reload goes back to LOAD
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] DEV_Addr,
  input  logic [31:0] DEV_WD,
  input  logic        WeDEV,
  output logic [31:0] DEV_RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state, state_nxt;
  logic              ctrl_en;
  logic [1:0]        ctrl_mode;
  logic              ctrl_im;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              irq_flag;

  logic              wr_ctrl, wr_preset;
  logic              auto_reload;
  logic              en_clr, flag_set, flag_clr;
  logic [31:0]       rd_data;

  // Address bits outside [3:2] are already qualified by the bridge.
  logic unused_bits;
  assign unused_bits = ^{DEV_Addr[31:4], DEV_Addr[1:0], DEV_WD};

  assign wr_ctrl     = WeDEV && (DEV_Addr[3:2] == A_CTRL);
  assign wr_preset   = WeDEV && (DEV_Addr[3:2] == A_PRESET);
  assign auto_reload = (ctrl_mode == 2'b01);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    en_clr    = 1'b0;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        count_nxt = preset;
        state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_nxt = S_IDLE;
        end else if (count > ONE) begin
          count_nxt = count - ONE;
        end else begin
          // PRESET of 0 or 1 both land here; the count saturates at zero.
          count_nxt = '0;
          flag_set  = 1'b1;
          state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          flag_clr  = 1'b1;
          state_nxt = S_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else begin
      count <= count_nxt;
      // A CPU write to CTRL overrides the FSM's one-shot EN clear on the same edge.
      if (wr_ctrl) begin
        ctrl_en   <= DEV_WD[0];
        ctrl_mode <= DEV_WD[2:1];
        ctrl_im   <= DEV_WD[3];
      end else if (en_clr) begin
        ctrl_en <= 1'b0;
      end
      if (wr_preset) preset <= DEV_WD[CNT_W-1:0];
      if (wr_ctrl || flag_clr) begin
        irq_flag <= 1'b0;
      end else if (flag_set) begin
        irq_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (DEV_Addr[3:2])
      A_CTRL:   rd_data[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
      A_PRESET: rd_data[CNT_W-1:0] = preset;
      A_COUNT:  rd_data[CNT_W-1:0] = count;
      default:  rd_data = '0;
    endcase
  end

  assign DEV_RD = rd_data;
  assign IRQ    = irq_flag & ctrl_im;

endmodule
